// File: rtl/pixel_stream_source.sv
// rtl/pixel_stream_source.sv - registered raster pixel-stream source with selectable test patterns
module pixel_stream_source #(
    parameter int          DATA_WIDTH = 12,
    parameter int          IMG_WIDTH  = 100,
    parameter int          PORCH      = 10,
    parameter int          IMG_HEIGHT = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [1:0]            pattern_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  de_img,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [11:0]           col,
    output logic [11:0]           row,
    output logic                  sof,
    output logic                  eol
);

    localparam logic [11:0] LAST_ACT = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] LAST_COL = 12'(IMG_WIDTH + PORCH - 1);
    localparam logic [11:0] LAST_ROW = 12'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [11:0]             col_n, row_n;
    logic [1:0]              pat, pat_n;
    logic [15:0]             lfsr, lfsr_n;
    logic                    done_n, sof_n, eol_n, de_n, line_end;
    logic [DATA_WIDTH-1:0]   data_n, pix;

    // Fibonacci form, taps 16,14,13,11, shifting toward the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign busy   = (state != S_IDLE);
    assign de_img = (state == S_ACTIVE);

    always_comb begin
        line_end = ((state == S_ACTIVE) && (col == LAST_ACT) && (PORCH == 0)) ||
                   ((state == S_BLANK) && (col == LAST_COL));
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        pat_n   = pat;
        lfsr_n  = lfsr;
        done_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ACTIVE;
                    col_n   = 12'd0;
                    row_n   = 12'd0;
                    pat_n   = pattern_sel;
                end
            end
            S_ACTIVE, S_BLANK: begin
                if (line_end) begin
                    col_n = 12'd0;
                    if (row == LAST_ROW) begin
                        state_n = S_IDLE;
                        row_n   = 12'd0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_ACTIVE;
                        row_n   = row + 12'd1;
                    end
                end else begin
                    col_n = col + 12'd1;
                    if ((state == S_ACTIVE) && (col == LAST_ACT))
                        state_n = S_BLANK;
                end
            end
            default: begin
                state_n = S_IDLE;
                col_n   = 12'd0;
                row_n   = 12'd0;
            end
        endcase

        de_n = (state_n == S_ACTIVE);

        // lfsr holds the value of the most recent active pixel, so porch cycles leave it untouched.
        if ((state == S_IDLE) && start)
            lfsr_n = LFSR_SEED;
        else if (de_n)
            lfsr_n = lfsr_step(lfsr);

        case (pat_n)
            2'd0:    pix = DATA_WIDTH'(((32'(row_n) + 32'd1) << 8) + 32'(col_n) + 32'd1);
            2'd1:    pix = DATA_WIDTH'(col_n);
            2'd2:    pix = {DATA_WIDTH{col_n[0] ^ row_n[0]}};
            default: pix = DATA_WIDTH'(lfsr_n);
        endcase

        data_n = de_n ? pix : '0;
        sof_n  = de_n && (row_n == 12'd0) && (col_n == 12'd0);
        eol_n  = de_n && (col_n == LAST_ACT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            col      <= 12'd0;
            row      <= 12'd0;
            pat      <= 2'd0;
            lfsr     <= LFSR_SEED;
            done     <= 1'b0;
            sof      <= 1'b0;
            eol      <= 1'b0;
            data_out <= '0;
        end else if (ce) begin
            state    <= state_n;
            col      <= col_n;
            row      <= row_n;
            pat      <= pat_n;
            lfsr     <= lfsr_n;
            done     <= done_n;
            sof      <= sof_n;
            eol      <= eol_n;
            data_out <= data_n;
        end
    end

endmodule

// File: tb/tb_pixel_stream_source.sv
// tb/tb_pixel_stream_source.sv - directed self-checking bench for pixel_stream_source
module tb_pixel_stream_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ce, start_a, start_b, start_c;
    logic [1:0] pattern_sel;

    logic        a_busy, a_done, a_de, a_sof, a_eol;
    logic [11:0] a_data, a_col, a_row;
    logic        b_busy, b_done, b_de, b_sof, b_eol;
    logic [11:0] b_data, b_col, b_row;
    logic        c_busy, c_done, c_de, c_sof, c_eol;
    logic [11:0] c_data, c_col, c_row;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    pixel_stream_source dut_a (
        .clk(clk), .rst(rst), .ce(ce), .start(start_a), .pattern_sel(pattern_sel),
        .busy(a_busy), .done(a_done), .de_img(a_de), .data_out(a_data),
        .col(a_col), .row(a_row), .sof(a_sof), .eol(a_eol)
    );

    pixel_stream_source #(.IMG_WIDTH(1), .PORCH(0), .IMG_HEIGHT(3)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .start(start_b), .pattern_sel(pattern_sel),
        .busy(b_busy), .done(b_done), .de_img(b_de), .data_out(b_data),
        .col(b_col), .row(b_row), .sof(b_sof), .eol(b_eol)
    );

    pixel_stream_source #(.IMG_WIDTH(3), .PORCH(0), .IMG_HEIGHT(1)) dut_c (
        .clk(clk), .rst(rst), .ce(ce), .start(start_c), .pattern_sel(pattern_sel),
        .busy(c_busy), .done(c_done), .de_img(c_de), .data_out(c_data),
        .col(c_col), .row(c_row), .sof(c_sof), .eol(c_eol)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [63:0] pack(input logic bs, input logic dn, input logic de,
                                         input logic sf, input logic el, input logic [11:0] r,
                                         input logic [11:0] c, input logic [11:0] d);
        return {23'b0, bs, dn, de, sf, el, r, c, d};
    endfunction

    function automatic logic [63:0] a_vec();
        return pack(a_busy, a_done, a_de, a_sof, a_eol, a_row, a_col, a_data);
    endfunction

    function automatic logic [63:0] b_vec();
        return pack(b_busy, b_done, b_de, b_sof, b_eol, b_row, b_col, b_data);
    endfunction

    function automatic logic [63:0] c_vec();
        return pack(c_busy, c_done, c_de, c_sof, c_eol, c_row, c_col, c_data);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    // Frame on the default instance (100+10 columns, 4 rows), busy ce-cycles i0..n-1.
    task automatic run_frame_a(input int pat, input int cediv, input int ign_at,
                               input int i0, input int n);
        logic [15:0] l;
        logic [11:0] d;
        logic        de;
        int          r, c;
        l = 16'hACE1;
        for (int i = i0; i < n; i++) begin
            r  = i / 110;
            c  = i % 110;
            de = (c < 100);
            case (pat)
                0:       d = 12'(((r + 1) << 8) + c + 1);
                1:       d = 12'(c);
                2:       d = (((c ^ r) & 1) != 0) ? 12'hFFF : 12'h000;
                default: d = l[11:0];
            endcase
            if (!de) d = 12'h000;
            for (int k = 0; k < cediv; k++) begin
                check("frame_a", i, a_vec(),
                      pack(1'b1, 1'b0, de, i == 0, c == 99, 12'(r), 12'(c), d));
                ce      = (k == cediv - 1);
                start_a = (i == ign_at) && (k == 0);
                tick();
            end
            if (de) l = lfsr_step(l);
        end
        start_a = 1'b0;
        ce      = 1'b1;
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        pattern_sel = 2'd0;
        tick();
        tick();
        check("reset_a", 0, a_vec(), pack(0, 0, 0, 0, 0, 12'd0, 12'd0, 12'd0));
        check("reset_b", 0, b_vec(), pack(0, 0, 0, 0, 0, 12'd0, 12'd0, 12'd0));
        check("reset_c", 0, c_vec(), pack(0, 0, 0, 0, 0, 12'd0, 12'd0, 12'd0));

        // Frame 1: counting pattern, stray start at busy cycle 200.
        rst = 1'b1; ce = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("first_pix", 0, 64'(a_data), 64'h101);
        run_frame_a(0, 1, 200, 0, 99);
        check("row0_last", 0, 64'({a_eol, a_data}), 64'h1164);
        run_frame_a(0, 1, 200, 99, 330);
        check("row3_first", 0, 64'({a_sof, a_row, a_data}), 64'h003401);
        run_frame_a(0, 1, 200, 330, 440);
        check("done1", 0, a_vec(), pack(0, 1, 0, 0, 0, 12'd0, 12'd0, 12'd0));

        // Start in the done cycle: back-to-back ramp frame; pattern change after acceptance is ignored.
        start_a = 1'b1; pattern_sel = 2'd1;
        tick();
        start_a = 1'b0; pattern_sel = 2'd2;
        run_frame_a(1, 1, -1, 0, 440);
        check("done2", 0, a_vec(), pack(0, 1, 0, 0, 0, 12'd0, 12'd0, 12'd0));
        tick();
        check("idle2", 0, a_vec(), pack(0, 0, 0, 0, 0, 12'd0, 12'd0, 12'd0));

        // Abort at row 1, col 50 with reset asserted while ce is low.
        pattern_sel = 2'd0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        run_frame_a(0, 1, -1, 0, 160);
        check("mid_line", 0, 64'({a_row, a_col, a_data}), 64'h001032233);
        rst = 1'b0; ce = 1'b0;
        tick();
        check("abort", 0, a_vec(), pack(0, 0, 0, 0, 0, 12'd0, 12'd0, 12'd0));
        rst = 1'b1; ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_done", i, a_vec(), pack(0, 0, 0, 0, 0, 12'd0, 12'd0, 12'd0));
        end

        // Restart after abort with ce at 1-in-3.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        run_frame_a(0, 3, -1, 0, 440);
        check("done3", 0, a_vec(), pack(0, 1, 0, 0, 0, 12'd0, 12'd0, 12'd0));

        // LFSR pattern twice back-to-back; each frame must restart from the seed.
        for (int f = 0; f < 2; f++) begin
            start_a = 1'b1; pattern_sel = 2'd3;
            tick();
            start_a = 1'b0; pattern_sel = 2'd0;
            check("lfsr_seed", f, 64'(a_data), 64'hCE1);
            run_frame_a(3, 1, -1, 0, 440);
            check("done_lfsr", f, a_vec(), pack(0, 1, 0, 0, 0, 12'd0, 12'd0, 12'd0));
        end
        tick();

        // Degenerate geometries: 1x3 with no porch, and 3x1 with no porch.
        start_b = 1'b1; start_c = 1'b1;
        tick();
        start_b = 1'b0; start_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("narrow_b", i, b_vec(),
                  pack(1, 0, 1, i == 0, 1, 12'(i), 12'd0, 12'(((i + 1) << 8) + 1)));
            check("short_c", i, c_vec(),
                  pack(1, 0, 1, i == 0, i == 2, 12'd0, 12'(i), 12'(256 + i + 1)));
            tick();
        end
        check("done_b", 0, b_vec(), pack(0, 1, 0, 0, 0, 12'd0, 12'd0, 12'd0));
        check("done_c", 0, c_vec(), pack(0, 1, 0, 0, 0, 12'd0, 12'd0, 12'd0));
        tick();
        check("idle_b", 0, b_vec(), pack(0, 0, 0, 0, 0, 12'd0, 12'd0, 12'd0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
